// File: rtl/matrix_pkg.sv
// Shared definitions for the sequential matrix ALU: op codes, FSM states,
// the saturating clip helper and the flat element index helper.
package matrix_pkg;

   localparam logic [2:0] OP_ADD   = 3'b000;
   localparam logic [2:0] OP_SUB   = 3'b001;
   localparam logic [2:0] OP_MUL   = 3'b010;
   localparam logic [2:0] OP_MULR  = 3'b011;
   localparam logic [2:0] OP_DET   = 3'b100;
   localparam logic [2:0] OP_TRANS = 3'b101;
   localparam logic [2:0] OP_OPP   = 3'b110;
   localparam logic [2:0] OP_CLR   = 3'b111;

   typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_EXEC, ST_FIN} state_t;

   typedef struct packed {
      logic signed [63:0] val;
      logic               ovf;
   } sat_t;

   // Clamp a sign-extended value into a w-bit signed range.
   function automatic sat_t sat_clip(input logic signed [63:0] x, input int w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      sat_t               s;
      hi    = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo    = -(64'sd1 <<< (w - 1));
      s.val = x;
      s.ovf = 1'b0;
      if (x > hi) begin
         s.val = hi;
         s.ovf = 1'b1;
      end else if (x < lo) begin
         s.val = lo;
         s.ovf = 1'b1;
      end
      return s;
   endfunction

   function automatic int idx(input int i, input int j, input int max_n);
      return i * max_n + j;
   endfunction

endpackage

// File: rtl/matrix_alu_sat.sv
// Combinational saturator: wide signed value in, OUT_W-bit clamped value out.
module matrix_alu_sat
   import matrix_pkg::*;
#(
   parameter int IN_W  = 27,
   parameter int OUT_W = 8
) (
   input  logic signed [IN_W-1:0]  din,
   output logic signed [OUT_W-1:0] dout,
   output logic                    ovf
);

   sat_t s;

   assign s    = sat_clip({{(64 - IN_W){din[IN_W-1]}}, din}, OUT_W);
   assign dout = s.val[OUT_W-1:0];
   assign ovf  = s.ovf;

endmodule

// File: rtl/matrix_alu_seq.sv
// Sequential saturating matrix ALU, one element-step per cycle.
// Determinant datapath is built only when MATRIX_ALU_DET_EN is defined.
module matrix_alu_seq
   import matrix_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int MAX_N  = 5,
   parameter int SIZE_W = 3
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic [2:0]                      op,
   input  logic [SIZE_W-1:0]               size,
   input  logic [MAX_N*MAX_N*DATA_W-1:0]   a_flat,
   input  logic [MAX_N*MAX_N*DATA_W-1:0]   b_flat,
   input  logic [DATA_W-1:0]               scalar,
   output logic [MAX_N*MAX_N*DATA_W-1:0]   result_flat,
   output logic                            busy,
   output logic                            done,
   output logic                            ovf,
   output logic                            err
);

   localparam int ACC_W  = 2 * DATA_W + $clog2(MAX_N) + 1;
   localparam int DET_W  = 3 * DATA_W + 3;
   localparam int WIDE_W = (ACC_W > DET_W) ? ACC_W : DET_W;

   state_t                    state;
   logic [2:0]                op_r;
   logic [SIZE_W-1:0]         n_r;
   logic [SIZE_W-1:0]         i, j, k;
   logic signed [DATA_W-1:0]  am [MAX_N][MAX_N];
   logic signed [DATA_W-1:0]  bm [MAX_N][MAX_N];
   logic signed [DATA_W-1:0]  res [MAX_N][MAX_N];
   logic signed [DATA_W-1:0]  scalar_r;
   logic signed [WIDE_W-1:0]  acc, wide, dterm;
   logic signed [DATA_W-1:0]  sat_val;
   logic                      sat_ovf;
   logic                      bad, last_i, last_j, last_k, last_det;

   function automatic logic signed [WIDE_W-1:0] ext(input logic signed [DATA_W-1:0] v);
      return WIDE_W'(v);
   endfunction

   // NOTE: operand copies have no reset; they are only read after a start has loaded them.
   always_ff @(posedge clk) begin
      if (state == ST_IDLE && start) begin
         for (int r = 0; r < MAX_N; r++)
            for (int c = 0; c < MAX_N; c++) begin
               am[r][c] <= a_flat[idx(r, c, MAX_N)*DATA_W +: DATA_W];
               bm[r][c] <= b_flat[idx(r, c, MAX_N)*DATA_W +: DATA_W];
            end
         scalar_r <= scalar;
      end
   end

   assign last_i   = (i == n_r - SIZE_W'(1));
   assign last_j   = (j == n_r - SIZE_W'(1));
   assign last_k   = (k == n_r - SIZE_W'(1));
   assign last_det = (n_r == SIZE_W'(2)) ? (k == SIZE_W'(1)) : (k == SIZE_W'(5));

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      bad = (n_r == '0) || (n_r > SIZE_W'(MAX_N));
`ifdef MATRIX_ALU_DET_EN
      if (op_r == OP_DET && n_r != SIZE_W'(2) && n_r != SIZE_W'(3)) bad = 1'b1;
`else
      if (op_r == OP_DET) bad = 1'b1;
`endif
   end

`ifdef MATRIX_ALU_DET_EN
   // Size 2 uses two terms; size 3 uses the six Sarrus triple products.
   always_comb begin
      dterm = '0;
      if (n_r == SIZE_W'(2)) begin
         if (k == '0) dterm = ext(am[0][0]) * ext(am[1][1]);
         else         dterm = -(ext(am[0][1]) * ext(am[1][0]));
      end else begin
         case (k)
            SIZE_W'(0): dterm =   ext(am[0][0]) * ext(am[1][1]) * ext(am[2][2]);
            SIZE_W'(1): dterm =   ext(am[0][1]) * ext(am[1][2]) * ext(am[2][0]);
            SIZE_W'(2): dterm =   ext(am[0][2]) * ext(am[1][0]) * ext(am[2][1]);
            SIZE_W'(3): dterm = -(ext(am[0][2]) * ext(am[1][1]) * ext(am[2][0]));
            SIZE_W'(4): dterm = -(ext(am[0][0]) * ext(am[1][2]) * ext(am[2][1]));
            default:    dterm = -(ext(am[0][1]) * ext(am[1][0]) * ext(am[2][2]));
         endcase
      end
   end
`else
   assign dterm = '0;
`endif

   always_comb begin
      wide = '0;
      case (op_r)
         OP_ADD:   wide = ext(am[i][j]) + ext(bm[i][j]);
         OP_SUB:   wide = ext(am[i][j]) - ext(bm[i][j]);
         OP_MULR:  wide = ext(am[i][j]) * ext(scalar_r);
         OP_TRANS: wide = ext(am[j][i]);
         OP_OPP:   wide = -ext(am[i][j]);
         OP_MUL:   wide = acc + ext(am[i][k]) * ext(bm[k][j]);
         OP_DET:   wide = acc + dterm;
         default:  wide = '0;
      endcase
   end

   matrix_alu_sat #(.IN_W(WIDE_W), .OUT_W(DATA_W)) u_sat (
      .din  (wide),
      .dout (sat_val),
      .ovf  (sat_ovf)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         op_r  <= '0;
         n_r   <= '0;
         i     <= '0;
         j     <= '0;
         k     <= '0;
         acc   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         ovf   <= 1'b0;
         err   <= 1'b0;
         for (int r = 0; r < MAX_N; r++)
            for (int c = 0; c < MAX_N; c++) res[r][c] <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: if (start) begin
               op_r  <= op;
               n_r   <= size;
               ovf   <= 1'b0;
               err   <= 1'b0;
               busy  <= 1'b1;
               state <= ST_CHECK;
            end
            ST_CHECK: begin
               i   <= '0;
               j   <= '0;
               k   <= '0;
               acc <= '0;
               if (bad) begin
                  err   <= 1'b1;
                  state <= ST_FIN;
               end else begin
                  for (int r = 0; r < MAX_N; r++)
                     for (int c = 0; c < MAX_N; c++)
                        if (op_r == OP_DET || r >= int'(n_r) || c >= int'(n_r)) res[r][c] <= '0;
                  state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (op_r == OP_CLR) begin
                  for (int r = 0; r < MAX_N; r++)
                     for (int c = 0; c < MAX_N; c++) res[r][c] <= '0;
                  state <= ST_FIN;
               end else if (op_r == OP_DET) begin
                  if (last_det) begin
                     res[0][0] <= sat_val;
                     ovf       <= ovf | sat_ovf;
                     state     <= ST_FIN;
                  end else begin
                     acc <= wide;
                     k   <= k + SIZE_W'(1);
                  end
               end else if (op_r == OP_MUL && !last_k) begin
                  acc <= wide;
                  k   <= k + SIZE_W'(1);
               end else begin
                  res[i][j] <= sat_val;
                  ovf       <= ovf | sat_ovf;
                  acc       <= '0;
                  k         <= '0;
                  if (last_j) begin
                     j <= '0;
                     if (last_i) state <= ST_FIN;
                     else        i     <= i + SIZE_W'(1);
                  end else begin
                     j <= j + SIZE_W'(1);
                  end
               end
            end
            ST_FIN: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      result_flat = '0;
      for (int r = 0; r < MAX_N; r++)
         for (int c = 0; c < MAX_N; c++)
            result_flat[idx(r, c, MAX_N)*DATA_W +: DATA_W] = res[r][c];
   end

endmodule

// File: tb/tb_matrix_alu_seq.sv
// Scoreboard bench for matrix_alu_seq: directed ops push expectations, a
// monitor pops and compares on every done pulse.
module tb_matrix_alu_seq;
   import matrix_pkg::*;

   localparam int DATA_W = 8;
   localparam int MAX_N  = 5;
   localparam int SIZE_W = 3;
   localparam int FW     = MAX_N * MAX_N * DATA_W;

   typedef logic [FW-1:0] flat_t;
   typedef int vec9_t [9];

   typedef struct {
      string name;
      flat_t res;
      logic  ovf;
      logic  err;
      int    lat;
      int    t0;
   } exp_t;

   exp_t sb[$];

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [2:0]        op = '0;
   logic [SIZE_W-1:0] size = '0;
   flat_t             a_flat = '0;
   flat_t             b_flat = '0;
   logic [DATA_W-1:0] scalar = '0;
   flat_t             result_flat;
   logic              busy, done, ovf, err;

   int    cyc = 0;
   int    n_checks = 0;
   int    n_pass = 0;
   flat_t prev = '0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   matrix_alu_seq #(.DATA_W(DATA_W), .MAX_N(MAX_N), .SIZE_W(SIZE_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .op          (op),
      .size        (size),
      .a_flat      (a_flat),
      .b_flat      (b_flat),
      .scalar      (scalar),
      .result_flat (result_flat),
      .busy        (busy),
      .done        (done),
      .ovf         (ovf),
      .err         (err)
   );

   task automatic check(input string name, input flat_t got, input flat_t want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %h want %h", name, got, want);
   endtask

   function automatic flat_t mk(input int n, input vec9_t v);
      flat_t f = '0;
      for (int r = 0; r < n; r++)
         for (int c = 0; c < n; c++)
            f[idx(r, c, MAX_N)*DATA_W +: DATA_W] = DATA_W'(v[r*n+c]);
      return f;
   endfunction

   // Issue one op, hold start for 'hold' edges, wait (bounded) for done.
   task automatic issue(input string name, input logic [2:0] o, input int n,
                        input flat_t a, input flat_t b, input int s,
                        input flat_t want, input logic wovf, input logic werr,
                        input int lat, input int hold);
      exp_t e;
      int   waited;
      @(negedge clk);
      op = o; size = SIZE_W'(n); a_flat = a; b_flat = b; scalar = DATA_W'(s); start = 1'b1;
      e.name = name; e.res = want; e.ovf = wovf; e.err = werr; e.lat = lat; e.t0 = cyc + 1;
      sb.push_back(e);
      prev = want;
      @(negedge clk);
      check({name, "_busy"}, FW'(busy), FW'(1));
      repeat (hold - 1) @(negedge clk);
      start = 1'b0; a_flat = ~a; b_flat = ~b; scalar = ~scalar;
      waited = 0;
      while (done !== 1'b1 && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      if (done !== 1'b1) check({name, "_done_seen"}, FW'(done), FW'(1));
      @(negedge clk);
      check({name, "_busy_after"}, FW'(busy), FW'(0));
   endtask

   always @(negedge clk) begin
      if (!rst && done === 1'b1) begin
         exp_t e;
         if (sb.size() == 0) begin
            check("unexpected_done", FW'(done), FW'(0));
         end else begin
            e = sb.pop_front();
            check({e.name, "_result"}, result_flat, e.res);
            check({e.name, "_ovf"}, FW'(ovf), FW'(e.ovf));
            check({e.name, "_err"}, FW'(err), FW'(e.err));
            check({e.name, "_latency"}, FW'(cyc - e.t0), FW'(e.lat));
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      flat_t ma, id3, big;
      ma  = mk(3, '{1, 2, 3, 4, 5, 6, 7, 8, 9});
      id3 = mk(3, '{1, 0, 0, 0, 1, 0, 0, 0, 1});

      repeat (3) @(negedge clk);
      check("rst_result", result_flat, '0);
      check("rst_busy", FW'(busy), '0);
      check("rst_done", FW'(done), '0);
      check("rst_ovf", FW'(ovf), '0);
      check("rst_err", FW'(err), '0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      issue("add2", OP_ADD, 2, mk(2, '{1, 2, 3, 4, 0, 0, 0, 0, 0}), mk(2, '{5, 6, 7, 8, 0, 0, 0, 0, 0}), 0,
            mk(2, '{6, 8, 10, 12, 0, 0, 0, 0, 0}), 1'b0, 1'b0, 6, 1);
      issue("mul3", OP_MUL, 3, ma, id3, 0, ma, 1'b0, 1'b0, 29, 1);
      issue("addsat", OP_ADD, 1, mk(1, '{100, 0, 0, 0, 0, 0, 0, 0, 0}), mk(1, '{100, 0, 0, 0, 0, 0, 0, 0, 0}), 0,
            mk(1, '{127, 0, 0, 0, 0, 0, 0, 0, 0}), 1'b1, 1'b0, 3, 1);
      issue("oppsat", OP_OPP, 1, mk(1, '{-128, 0, 0, 0, 0, 0, 0, 0, 0}), '0, 0,
            mk(1, '{127, 0, 0, 0, 0, 0, 0, 0, 0}), 1'b1, 1'b0, 3, 1);
      issue("sub2", OP_SUB, 2, mk(2, '{10, -20, 0, -128, 0, 0, 0, 0, 0}), mk(2, '{3, 5, -7, 1, 0, 0, 0, 0, 0}), 0,
            mk(2, '{7, -25, 7, -128, 0, 0, 0, 0, 0}), 1'b1, 1'b0, 6, 1);
      issue("mulr2", OP_MULR, 2, mk(2, '{3, -4, 50, 0, 0, 0, 0, 0, 0}), '0, 3,
            mk(2, '{9, -12, 127, 0, 0, 0, 0, 0, 0}), 1'b1, 1'b0, 6, 1);
      issue("trans3", OP_TRANS, 3, ma, '0, 0,
            mk(3, '{1, 4, 7, 2, 5, 8, 3, 6, 9}), 1'b0, 1'b0, 11, 1);
      issue("size0", OP_ADD, 0, ma, ma, 0, prev, 1'b0, 1'b1, 2, 3);
      issue("size6", OP_ADD, 6, ma, ma, 0, prev, 1'b0, 1'b1, 2, 3);
`ifdef MATRIX_ALU_DET_EN
      issue("det3", OP_DET, 3, mk(3, '{2, 0, 1, 1, 3, 2, 1, 1, 1}), '0, 0, '0, 1'b0, 1'b0, 8, 1);
      issue("det2", OP_DET, 2, mk(2, '{2, 1, 1, 3, 0, 0, 0, 0, 0}), '0, 0,
            mk(1, '{5, 0, 0, 0, 0, 0, 0, 0, 0}), 1'b0, 1'b0, 4, 1);
`else
      issue("det3", OP_DET, 3, mk(3, '{2, 0, 1, 1, 3, 2, 1, 1, 1}), '0, 0, prev, 1'b0, 1'b1, 2, 1);
      issue("det2", OP_DET, 2, mk(2, '{2, 1, 1, 3, 0, 0, 0, 0, 0}), '0, 0, prev, 1'b0, 1'b1, 2, 1);
`endif
      issue("det4", OP_DET, 4, ma, '0, 0, prev, 1'b0, 1'b1, 2, 1);
      issue("clr4", OP_CLR, 4, ma, ma, 0, '0, 1'b0, 1'b0, 3, 1);

      // Start a long 5x5 multiply that saturates early, then abort it with reset.
      big = '0;
      for (int e = 0; e < MAX_N * MAX_N; e++) big[e*DATA_W +: DATA_W] = DATA_W'(100);
      @(negedge clk);
      op = OP_MUL; size = SIZE_W'(5); a_flat = big; b_flat = big; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (20) @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_result", result_flat, '0);
      check("abort_busy", FW'(busy), '0);
      check("abort_done", FW'(done), '0);
      check("abort_ovf", FW'(ovf), '0);
      check("abort_err", FW'(err), '0);
      @(negedge clk);
      rst = 1'b0;
      prev = '0;
      repeat (10) @(negedge clk);

      issue("trans1", OP_TRANS, 1, mk(1, '{-5, 0, 0, 0, 0, 0, 0, 0, 0}), '0, 0,
            mk(1, '{-5, 0, 0, 0, 0, 0, 0, 0, 0}), 1'b0, 1'b0, 3, 1);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", FW'(sb.size()), '0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/matrix_alu_seq.md
Name: matrix_alu_seq

Overview:
Parametrised, sequential successor to the combinational element ALU in the matrix coprocessor. Executes a whole matrix operation (add, sub, matrix multiply, scalar multiply, determinant, transpose, opposite, clear) on up to MAX_N x MAX_N signed matrices. Sits between the coprocessor's operand register bank and the result bank. Uses a start/busy/done handshake, one element-step per cycle, and saturating arithmetic.

Parameters:
DATA_W, 8, signed element width in bits
MAX_N, 5, largest supported matrix dimension
SIZE_W, 3, width of the size input; must hold MAX_N

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  request; sampled only in IDLE
op  in  3  operation code, latched at start
size  in  SIZE_W  active dimension n, latched at start
a_flat  in  MAX_N*MAX_N*DATA_W  operand A; element (i,j) at bits [(i*MAX_N+j)*DATA_W +: DATA_W]
b_flat  in  MAX_N*MAX_N*DATA_W  operand B; same layout
scalar  in  DATA_W  signed multiplier for op 011, latched at start
result_flat  out  MAX_N*MAX_N*DATA_W  result matrix; same layout; registered
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse at completion
ovf  out  1  any saturation occurred in the last op; valid with done, held until next start
err  out  1  invalid size or op for that size; valid with done, held until next start

Behaviour:
- Reset (async, active-high) sets result_flat=0, busy=0, done=0, ovf=0, err=0, FSM=IDLE, counters=0. Reset mid-operation aborts the op; no done pulse is produced.
- FSM states: IDLE, CHECK, EXEC, FIN.
- IDLE: on start=1, latch op, size, a_flat, b_flat and scalar. Clear ovf and err. Go to CHECK. start is ignored in every other state.
- CHECK (1 cycle): busy=1.
  - Invalid if size==0, size>MAX_N, or op=100 with size not in {2,3}. Invalid -> set err=1, leave result unchanged, go to FIN.
  - Valid -> zero every result element outside the n x n region, reset counters i, j, k to 0, go to EXEC.
- EXEC, elementwise ops: one element (i,j) per cycle, row-major; n*n cycles.
  - 000: a+b
  - 001: a-b
  - 011: a*scalar
  - 101: result(i,j)=a(j,i)
  - 110: -a
- EXEC, 010 matrix multiply: accumulator of width 2*DATA_W+$clog2(MAX_N)+1, one MAC per cycle over k. Write result(i,j) after k=n-1; n*n*n cycles.
- EXEC, 100 determinant: one signed term per cycle into the accumulator. Size 2: 2 terms. Size 3: 6 cofactor triple-products (Sarrus order). The final value goes to result(0,0); all other elements are 0.
- EXEC, 111 clear: result_flat=0 in a single EXEC cycle.
- Counter wrap: j wraps to 0 and increments i. After (n-1,n-1), go to FIN.
- FIN: done=1 for one cycle, busy=0 on the following cycle, return to IDLE. A start asserted in the FIN cycle is ignored.
- Total latency from the start cycle to done:
  - elementwise ops: n*n+2 cycles
  - 010: n^3+2 cycles
  - 111: 3 cycles
  - invalid op/size: 2 cycles
- Arithmetic: compute at full width, then saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. Any clamp sets ovf. Negating -128 saturates to +127 and sets ovf.
- result_flat is stable whenever busy=0. Inputs may change freely after the start cycle.

Optional Feature:
MATRIX_ALU_DET_EN
- Defined: op 100 behaves as above.
- Undefined: the determinant datapath is omitted; op 100 always sets err=1 with 2-cycle latency and leaves result unchanged.

Decomposition:
- Shared package matrix_pkg holds:
  - op code localparams OP_ADD=000, OP_SUB=001, OP_MUL=010, OP_MULR=011, OP_DET=100, OP_TRANS=101, OP_OPP=110, OP_CLR=111
  - FSM state encoding
  - a sat_clip function (full width to DATA_W, with overflow flag)
  - the element index helper (i*MAX_N+j)
- One natural sub-module, matrix_alu_sat: combinational saturator (wide signed in, DATA_W out, ovf out), shared by all paths.

Test Plan:
- Add 2x2 [[1,2],[3,4]]+[[5,6],[7,8]] -> [[6,8],[10,12]]; done 6 cycles after start; ovf=0, err=0.
- Multiply 3x3 A=[[1,2,3],[4,5,6],[7,8,9]] by B=identity -> result==A; done at cycle 29; result is 0 outside 3x3.
- Saturation: op 000 on 1x1 with 100+100 -> 127, ovf=1; op 110 on 1x1 with a=-128 -> 127, ovf=1.
- Determinant 3x3 [[2,0,1],[1,3,2],[1,1,1]] -> result(0,0)=0; [[2,1],[1,3]] -> 5. With the macro undefined, both cases -> err=1, result unchanged.
- size=0 and size=6 -> err=1, done 2 cycles after start; start held high during busy does not retrigger.
- Assert rst mid-multiply on 5x5 -> all outputs 0 immediately, no done; a following 1x1 transpose completes normally.
